// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount accumulator slice.
//
// Contents:
//   DEF_CNT_WIDTH / DEF_WINDOW : default incoming count width and window length
//   popcount_stat_t            : {sum, max, words} window statistics record,
//                                sized for the default parameters (CSR side)
//   out_state_t                : output register state (EMPTY / FULL)
package popcount_pkg;

  localparam int DEF_CNT_WIDTH  = 5;
  localparam int DEF_WINDOW     = 16;
  localparam int DEF_SUM_WIDTH  = DEF_CNT_WIDTH + $clog2(DEF_WINDOW);
  localparam int DEF_WCNT_WIDTH = $clog2(DEF_WINDOW) + 1;

  typedef struct packed {
    logic [DEF_SUM_WIDTH-1:0]  sum;
    logic [DEF_CNT_WIDTH-1:0]  max;
    logic [DEF_WCNT_WIDTH-1:0] words;
  } popcount_stat_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/popcount_window_acc.sv
// Window accumulator datapath and close detection.
//
// Accumulates sum, peak and word count of valid input counts. When the
// window closes (WINDOW words reached, or an effective flush) it raises
// close_o combinationally in that cycle, with stat_o carrying the final
// values including the current word, and clears the accumulator at the
// same edge so the next word starts a fresh window.
//
// Ports:
//   clk_i       : clock
//   srst_i      : synchronous active-high reset, discards a partial window
//   data_i      : popcount of one word
//   data_val_i  : data_i qualifier
//   flush_i     : close the current window early
//   close_o     : window closes this cycle
//   stat_o      : final {sum, max, words} of the closing window
module popcount_window_acc
  import popcount_pkg::*;
#(
  parameter int  CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int  WINDOW    = DEF_WINDOW,
  parameter type stat_t    = popcount_stat_t
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [CNT_WIDTH-1:0] data_i,
  input  logic                 data_val_i,
  input  logic                 flush_i,
  output logic                 close_o,
  output stat_t                stat_o
);

  localparam int SUM_WIDTH  = CNT_WIDTH + $clog2(WINDOW);
  localparam int WCNT_WIDTH = $clog2(WINDOW) + 1;

  logic [SUM_WIDTH-1:0]  acc_sum, sum_next;
  logic [CNT_WIDTH-1:0]  acc_max, max_next;
  logic [WCNT_WIDTH-1:0] acc_cnt, cnt_next;

  // Next values include the current word, so the closing word is part of
  // the reported window.
  always_comb begin
    sum_next = acc_sum;
    max_next = acc_max;
    cnt_next = acc_cnt;
    if (data_val_i) begin
      sum_next = acc_sum + SUM_WIDTH'(data_i);
      if (data_i > acc_max) begin
        max_next = data_i;
      end
      cnt_next = acc_cnt + WCNT_WIDTH'(1);
    end
    // A flush with nothing accumulated and no incoming word is ignored.
    close_o = (data_val_i && (cnt_next == WCNT_WIDTH'(WINDOW))) ||
              (flush_i && ((acc_cnt != '0) || data_val_i));
    stat_o       = '0;
    stat_o.sum   = sum_next;
    stat_o.max   = max_next;
    stat_o.words = cnt_next;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i || close_o) begin
      acc_sum <= '0;
      acc_max <= '0;
      acc_cnt <= '0;
    end else begin
      acc_sum <= sum_next;
      acc_max <= max_next;
      acc_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/popcount_accumulator.sv
// Windowed popcount accumulator with a valid/ready result register.
//
// Handshake: sum_val_o/sum_ready_i follow valid/ready semantics -- a result
// transfers on a cycle where both are high; while sum_val_o is high and
// sum_ready_i low, sum_o/max_o/words_o hold steady; sum_ready_i is ignored
// while sum_val_o is low. Input side (data_val_i) has no backpressure: a
// window closing while an unaccepted result is held is dropped and
// overrun_o pulses for one cycle.
//
// Ports:
//   clk_i       : clock
//   srst_i      : synchronous active-high reset
//   data_i      : popcount of one word (CNT_WIDTH)
//   data_val_i  : data_i valid
//   flush_i     : close the current window early
//   sum_o       : sum of counts in the closed window (SUM_WIDTH)
//   max_o       : largest single count in the window (CNT_WIDTH)
//   words_o     : words in the window, 1..WINDOW (WCNT_WIDTH)
//   sum_val_o   : result valid
//   sum_ready_i : consumer accepts the result
//   overrun_o   : one-cycle pulse when a closed window was dropped
module popcount_accumulator
  import popcount_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int WINDOW    = DEF_WINDOW,
  localparam int SUM_WIDTH  = CNT_WIDTH + $clog2(WINDOW),
  localparam int WCNT_WIDTH = $clog2(WINDOW) + 1
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [CNT_WIDTH-1:0]  data_i,
  input  logic                  data_val_i,
  input  logic                  flush_i,
  output logic [SUM_WIDTH-1:0]  sum_o,
  output logic [CNT_WIDTH-1:0]  max_o,
  output logic [WCNT_WIDTH-1:0] words_o,
  output logic                  sum_val_o,
  input  logic                  sum_ready_i,
  output logic                  overrun_o
);

  // Same layout as popcount_stat_t, sized for this instance's parameters.
  typedef struct packed {
    logic [SUM_WIDTH-1:0]  sum;
    logic [CNT_WIDTH-1:0]  max;
    logic [WCNT_WIDTH-1:0] words;
  } stat_t;

  logic       close;
  stat_t      stat;
  stat_t      res_q;
  out_state_t state_q, state_d;
  logic       load;
  logic       overrun_d, overrun_q;

  popcount_window_acc #(
    .CNT_WIDTH (CNT_WIDTH),
    .WINDOW    (WINDOW),
    .stat_t    (stat_t)
  ) u_acc (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .data_i     (data_i),
    .data_val_i (data_val_i),
    .flush_i    (flush_i),
    .close_o    (close),
    .stat_o     (stat)
  );

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (close) begin
          load    = 1'b1;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (close && sum_ready_i) begin
          // Held result leaves as the new one arrives: no bubble.
          load = 1'b1;
        end else if (close) begin
          // Held result has priority; the new window is lost.
          overrun_d = 1'b1;
        end else if (sum_ready_i) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= OUT_EMPTY;
      res_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
      if (load) begin
        res_q <= stat;
      end
    end
  end

  assign sum_o     = res_q.sum;
  assign max_o     = res_q.max;
  assign words_o   = res_q.words;
  assign sum_val_o = (state_q == OUT_FULL);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_popcount_accumulator.sv
module tb_popcount_accumulator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  // WINDOW=4 instance
  logic [4:0] d4;
  logic       v4, f4, r4;
  logic [6:0] s4;
  logic [4:0] m4;
  logic [2:0] w4;
  logic       sv4, ov4;

  // WINDOW=16 (default) instance
  logic [4:0] d16;
  logic       v16, f16, r16;
  logic [8:0] s16;
  logic [4:0] m16;
  logic [4:0] w16;
  logic       sv16, ov16;

  int checks = 0;
  int errors = 0;

  popcount_accumulator #(.CNT_WIDTH(5), .WINDOW(4)) dut4 (
    .clk_i(clk), .srst_i(srst), .data_i(d4), .data_val_i(v4), .flush_i(f4),
    .sum_o(s4), .max_o(m4), .words_o(w4), .sum_val_o(sv4),
    .sum_ready_i(r4), .overrun_o(ov4)
  );

  popcount_accumulator dut16 (
    .clk_i(clk), .srst_i(srst), .data_i(d16), .data_val_i(v16), .flush_i(f16),
    .sum_o(s16), .max_o(m16), .words_o(w16), .sum_val_o(sv16),
    .sum_ready_i(r16), .overrun_o(ov16)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv4(input logic [4:0] d, input logic v, input logic f);
    d4 = d; v4 = v; f4 = f;
    step();
    d4 = '0; v4 = 1'b0; f4 = 1'b0;
  endtask

  task automatic drv16(input logic [4:0] d, input logic v);
    d16 = d; v16 = v;
    step();
    d16 = '0; v16 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    srst = 1'b1;
    d4 = '0; v4 = 0; f4 = 0; r4 = 1;
    d16 = '0; v16 = 0; f16 = 0; r16 = 1;
    step(); step();
    checks++; if (sv4 !== 1'b0) begin errors++; $display("FAIL rst_val4: got %0d expected 0", sv4); end
    checks++; if (s4 !== 7'd0) begin errors++; $display("FAIL rst_sum4: got %0d expected 0", s4); end
    checks++; if (m4 !== 5'd0) begin errors++; $display("FAIL rst_max4: got %0d expected 0", m4); end
    checks++; if (w4 !== 3'd0) begin errors++; $display("FAIL rst_words4: got %0d expected 0", w4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL rst_ovr4: got %0d expected 0", ov4); end
    checks++; if (sv16 !== 1'b0) begin errors++; $display("FAIL rst_val16: got %0d expected 0", sv16); end
    checks++; if (s16 !== 9'd0) begin errors++; $display("FAIL rst_sum16: got %0d expected 0", s16); end
    srst = 1'b0;
    step();
  endtask

  task automatic test_full_window();
    r4 = 1'b1;
    drv4(5'd3, 1, 0);
    drv4(5'd5, 1, 0);
    drv4(5'd0, 1, 0);
    checks++; if (sv4 !== 1'b0) begin errors++; $display("FAIL t1_early_val: got %0d expected 0", sv4); end
    drv4(5'd24, 1, 0);
    checks++; if (sv4 !== 1'b1) begin errors++; $display("FAIL t1_val: got %0d expected 1", sv4); end
    checks++; if (s4 !== 7'd32) begin errors++; $display("FAIL t1_sum: got %0d expected 32", s4); end
    checks++; if (m4 !== 5'd24) begin errors++; $display("FAIL t1_max: got %0d expected 24", m4); end
    checks++; if (w4 !== 3'd4) begin errors++; $display("FAIL t1_words: got %0d expected 4", w4); end
    // second window starts immediately
    drv4(5'd1, 1, 0);
    checks++; if (sv4 !== 1'b0) begin errors++; $display("FAIL t1_val_pulse: got %0d expected 0", sv4); end
    drv4(5'd1, 1, 0);
    drv4(5'd1, 1, 0);
    drv4(5'd1, 1, 0);
    checks++; if (sv4 !== 1'b1) begin errors++; $display("FAIL t1b_val: got %0d expected 1", sv4); end
    checks++; if (s4 !== 7'd4) begin errors++; $display("FAIL t1b_sum: got %0d expected 4", s4); end
    checks++; if (m4 !== 5'd1) begin errors++; $display("FAIL t1b_max: got %0d expected 1", m4); end
    checks++; if (w4 !== 3'd4) begin errors++; $display("FAIL t1b_words: got %0d expected 4", w4); end
    drv4(5'd0, 0, 0);
    checks++; if (sv4 !== 1'b0) begin errors++; $display("FAIL t1b_accept: got %0d expected 0", sv4); end
  endtask

  task automatic test_flush();
    r4 = 1'b1;
    drv4(5'd7, 1, 0);
    drv4(5'd0, 0, 0);
    drv4(5'd0, 0, 0);
    drv4(5'd9, 1, 0);
    drv4(5'd0, 0, 0);
    checks++; if (sv4 !== 1'b0) begin errors++; $display("FAIL t2_pre_val: got %0d expected 0", sv4); end
    drv4(5'd0, 0, 1);
    checks++; if (sv4 !== 1'b1) begin errors++; $display("FAIL t2_val: got %0d expected 1", sv4); end
    checks++; if (s4 !== 7'd16) begin errors++; $display("FAIL t2_sum: got %0d expected 16", s4); end
    checks++; if (m4 !== 5'd9) begin errors++; $display("FAIL t2_max: got %0d expected 9", m4); end
    checks++; if (w4 !== 3'd2) begin errors++; $display("FAIL t2_words: got %0d expected 2", w4); end
    drv4(5'd0, 0, 0);
    // flush on an empty window must do nothing
    drv4(5'd0, 0, 1);
    checks++; if (sv4 !== 1'b0) begin errors++; $display("FAIL t2_empty_flush_val: got %0d expected 0", sv4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL t2_empty_flush_ovr: got %0d expected 0", ov4); end
  endtask

  task automatic test_flush_with_word();
    r4 = 1'b1;
    drv4(5'd2, 1, 0);
    drv4(5'd2, 1, 0);
    drv4(5'd6, 1, 1);
    checks++; if (sv4 !== 1'b1) begin errors++; $display("FAIL t3_val: got %0d expected 1", sv4); end
    checks++; if (s4 !== 7'd10) begin errors++; $display("FAIL t3_sum: got %0d expected 10", s4); end
    checks++; if (m4 !== 5'd6) begin errors++; $display("FAIL t3_max: got %0d expected 6", m4); end
    checks++; if (w4 !== 3'd3) begin errors++; $display("FAIL t3_words: got %0d expected 3", w4); end
    drv4(5'd3, 1, 0);
    drv4(5'd3, 1, 0);
    drv4(5'd3, 1, 0);
    drv4(5'd3, 1, 0);
    checks++; if (s4 !== 7'd12) begin errors++; $display("FAIL t3b_sum: got %0d expected 12", s4); end
    checks++; if (m4 !== 5'd3) begin errors++; $display("FAIL t3b_max: got %0d expected 3", m4); end
    checks++; if (w4 !== 3'd4) begin errors++; $display("FAIL t3b_words: got %0d expected 4", w4); end
    drv4(5'd0, 0, 0);
  endtask

  task automatic test_overrun();
    r4 = 1'b0;
    for (int i = 0; i < 4; i++) drv4(5'd2, 1, 0);
    checks++; if (s4 !== 7'd8) begin errors++; $display("FAIL t4_a_sum: got %0d expected 8", s4); end
    for (int i = 0; i < 3; i++) drv4(5'd3, 1, 0);
    checks++; if (s4 !== 7'd8) begin errors++; $display("FAIL t4_hold_sum: got %0d expected 8", s4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL t4_pre_ovr: got %0d expected 0", ov4); end
    drv4(5'd3, 1, 0);
    checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL t4_ovr: got %0d expected 1", ov4); end
    checks++; if (s4 !== 7'd8) begin errors++; $display("FAIL t4_drop_sum: got %0d expected 8", s4); end
    checks++; if (m4 !== 5'd2) begin errors++; $display("FAIL t4_drop_max: got %0d expected 2", m4); end
    checks++; if (sv4 !== 1'b1) begin errors++; $display("FAIL t4_drop_val: got %0d expected 1", sv4); end
    drv4(5'd0, 0, 0);
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL t4_ovr_pulse: got %0d expected 0", ov4); end
    r4 = 1'b1;
    drv4(5'd0, 0, 0);
    checks++; if (sv4 !== 1'b0) begin errors++; $display("FAIL t4_accept: got %0d expected 0", sv4); end
    drv4(5'd0, 0, 0);
    checks++; if (sv4 !== 1'b0) begin errors++; $display("FAIL t4_b_dropped: got %0d expected 0", sv4); end
    drv4(5'd5, 1, 1);
    checks++; if (sv4 !== 1'b1) begin errors++; $display("FAIL t4_c_val: got %0d expected 1", sv4); end
    checks++; if (s4 !== 7'd5) begin errors++; $display("FAIL t4_c_sum: got %0d expected 5", s4); end
    checks++; if (w4 !== 3'd1) begin errors++; $display("FAIL t4_c_words: got %0d expected 1", w4); end
    drv4(5'd0, 0, 0);
  endtask

  task automatic test_back_to_back();
    r4 = 1'b0;
    for (int i = 0; i < 4; i++) drv4(5'd1, 1, 0);
    checks++; if (s4 !== 7'd4) begin errors++; $display("FAIL t5_a_sum: got %0d expected 4", s4); end
    drv4(5'd4, 1, 0);
    drv4(5'd4, 1, 0);
    drv4(5'd4, 1, 0);
    r4 = 1'b1;
    drv4(5'd0, 1, 0);
    checks++; if (sv4 !== 1'b1) begin errors++; $display("FAIL t5_val: got %0d expected 1", sv4); end
    checks++; if (s4 !== 7'd12) begin errors++; $display("FAIL t5_sum: got %0d expected 12", s4); end
    checks++; if (m4 !== 5'd4) begin errors++; $display("FAIL t5_max: got %0d expected 4", m4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL t5_ovr: got %0d expected 0", ov4); end
    drv4(5'd0, 0, 0);
    checks++; if (sv4 !== 1'b0) begin errors++; $display("FAIL t5_accept: got %0d expected 0", sv4); end
  endtask

  task automatic test_default_window();
    r16 = 1'b1;
    for (int i = 0; i < 15; i++) drv16(5'd24, 1);
    checks++; if (sv16 !== 1'b0) begin errors++; $display("FAIL t6_early_val: got %0d expected 0", sv16); end
    drv16(5'd24, 1);
    checks++; if (sv16 !== 1'b1) begin errors++; $display("FAIL t6_val: got %0d expected 1", sv16); end
    checks++; if (s16 !== 9'd384) begin errors++; $display("FAIL t6_sum: got %0d expected 384", s16); end
    checks++; if (m16 !== 5'd24) begin errors++; $display("FAIL t6_max: got %0d expected 24", m16); end
    checks++; if (w16 !== 5'd16) begin errors++; $display("FAIL t6_words: got %0d expected 16", w16); end
    drv16(5'd0, 0);
    // reset discards a partial window
    for (int i = 0; i < 5; i++) drv16(5'd7, 1);
    srst = 1'b1;
    step();
    srst = 1'b0;
    checks++; if (sv16 !== 1'b0) begin errors++; $display("FAIL t6_rst_val: got %0d expected 0", sv16); end
    for (int i = 0; i < 16; i++) drv16(5'd1, 1);
    checks++; if (sv16 !== 1'b1) begin errors++; $display("FAIL t6r_val: got %0d expected 1", sv16); end
    checks++; if (s16 !== 9'd16) begin errors++; $display("FAIL t6r_sum: got %0d expected 16", s16); end
    checks++; if (m16 !== 5'd1) begin errors++; $display("FAIL t6r_max: got %0d expected 1", m16); end
    checks++; if (w16 !== 5'd16) begin errors++; $display("FAIL t6r_words: got %0d expected 16", w16); end
    drv16(5'd0, 0);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_full_window();
    test_flush();
    test_flush_with_word();
    test_overrun();
    test_back_to_back();
    test_default_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
